// File: rtl/wave_pkg.sv
// Definitions shared by the wave capture block and the wave display.
package wave_pkg;

  typedef logic [1:0] wc_state_t;

  localparam wc_state_t WC_ARMED  = 2'd0;
  localparam wc_state_t WC_ACTIVE = 2'd1;
  localparam wc_state_t WC_WAIT   = 2'd2;

  localparam int unsigned WAVE_DEPTH_LOG2  = 8;
  localparam int unsigned WAVE_PIXEL_WIDTH = 8;

endpackage

// File: rtl/wave_capture_if.sv
// Sample input, display handshake and RAM write port of the wave capture block.
interface wave_capture_if #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2   = 8
);
  import wave_pkg::*;

  logic                        new_sample_ready;
  logic [SAMPLE_WIDTH-1:0]     new_sample_in;
  logic                        wave_display_idle;
  logic [DEPTH_LOG2:0]         write_address;
  logic                        write_enable;
  logic [WAVE_PIXEL_WIDTH-1:0] write_sample;
  logic                        read_index;

  // Capture block side.
  modport master (
    input  new_sample_ready,
    input  new_sample_in,
    input  wave_display_idle,
    output write_address,
    output write_enable,
    output write_sample,
    output read_index
  );

  // Sample source / display / RAM side.
  modport slave (
    output new_sample_ready,
    output new_sample_in,
    output wave_display_idle,
    input  write_address,
    input  write_enable,
    input  write_sample,
    input  read_index
  );

endinterface

// File: rtl/dff.sv
// Register cell with synchronous active-high reset to a parameterised value.
module dff #(
  parameter int unsigned      Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_o <= ResetVal;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/wave_capture.sv
// Captures one window of samples, starting at a positive-going zero crossing, into the
// back half of a double-buffered display RAM, then swaps halves once the display is idle.
module wave_capture
  import wave_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2   = WAVE_DEPTH_LOG2
) (
  input logic            clk,
  input logic            reset,
  wave_capture_if.master bus
);

  localparam int unsigned PixW  = WAVE_PIXEL_WIDTH;
  localparam int unsigned AddrW = DEPTH_LOG2 + 1;

  wc_state_t             state_q, state_d;
  logic [DEPTH_LOG2-1:0] count_q, count_d;
  logic                  prev_msb_q, prev_msb_d;
  logic                  read_index_q, read_index_d;
  logic                  write_enable_q, write_enable_d;
  logic [AddrW-1:0]      write_address_q, write_address_d;
  logic [PixW-1:0]       write_sample_q, write_sample_d;

  logic            sample_msb;
  logic            crossing;
  logic            last_index;
  logic [PixW-1:0] pixel;
  logic            unused_low_bits;

  assign sample_msb = bus.new_sample_in[SAMPLE_WIDTH-1];
  assign crossing   = bus.new_sample_ready & prev_msb_q & ~sample_msb;
  assign last_index = (count_q == {DEPTH_LOG2{1'b1}});
  // Offset binary: flip the sign bit of the top pixel-width bits.
  assign pixel      = {~sample_msb, bus.new_sample_in[SAMPLE_WIDTH-2 -: PixW-1]};
  assign unused_low_bits = ^bus.new_sample_in[SAMPLE_WIDTH-PixW-1:0];

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    read_index_d    = read_index_q;
    prev_msb_d      = bus.new_sample_ready ? sample_msb : prev_msb_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_sample_d  = write_sample_q;

    case (state_q)
      WC_ARMED: begin
        if (crossing) begin
          write_enable_d  = 1'b1;
          write_address_d = {~read_index_q, count_q};
          write_sample_d  = pixel;
          count_d         = DEPTH_LOG2'(1);
          state_d         = WC_ACTIVE;
        end
      end
      WC_ACTIVE: begin
        if (bus.new_sample_ready) begin
          write_enable_d  = 1'b1;
          write_address_d = {~read_index_q, count_q};
          write_sample_d  = pixel;
          count_d         = count_q + 1'b1;
          if (last_index) begin
            state_d = WC_WAIT;
          end
        end
      end
      WC_WAIT: begin
        // Any pulse arriving here is dropped, even one coinciding with the swap.
        if (bus.wave_display_idle) begin
          read_index_d = ~read_index_q;
          state_d      = WC_ARMED;
        end
      end
      default: begin
        state_d = WC_ARMED;
        count_d = '0;
      end
    endcase
  end

  dff #(.Width(2), .ResetVal(WC_ARMED)) u_state (
    .clk   (clk),
    .reset (reset),
    .d_i   (state_d),
    .q_o   (state_q)
  );

  dff #(.Width(DEPTH_LOG2)) u_count (
    .clk   (clk),
    .reset (reset),
    .d_i   (count_d),
    .q_o   (count_q)
  );

  dff #(.Width(1)) u_prev_msb (
    .clk   (clk),
    .reset (reset),
    .d_i   (prev_msb_d),
    .q_o   (prev_msb_q)
  );

  dff #(.Width(1)) u_read_index (
    .clk   (clk),
    .reset (reset),
    .d_i   (read_index_d),
    .q_o   (read_index_q)
  );

  dff #(.Width(1)) u_write_enable (
    .clk   (clk),
    .reset (reset),
    .d_i   (write_enable_d),
    .q_o   (write_enable_q)
  );

  dff #(.Width(AddrW)) u_write_address (
    .clk   (clk),
    .reset (reset),
    .d_i   (write_address_d),
    .q_o   (write_address_q)
  );

  dff #(.Width(PixW)) u_write_sample (
    .clk   (clk),
    .reset (reset),
    .d_i   (write_sample_d),
    .q_o   (write_sample_q)
  );

  assign bus.write_enable  = write_enable_q;
  assign bus.write_address = write_address_q;
  assign bus.write_sample  = write_sample_q;
  assign bus.read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// Randomised bench for wave_capture against a window-level reference model.
module tb_wave_capture;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wave_capture_if #(.SAMPLE_WIDTH(16), .DEPTH_LOG2(8)) bus ();

  wave_capture #(.SAMPLE_WIDTH(16), .DEPTH_LOG2(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: m_idx = next window slot (-1 while armed), m_wait = window full.
  int m_idx;
  bit m_wait;
  bit m_ri;
  bit m_prev;
  bit exp_we;
  int exp_addr;
  int exp_data;

  task automatic step(input bit rdy, input logic [15:0] s, input bit idle);
    bus.new_sample_ready  = rdy;
    bus.new_sample_in     = s;
    bus.wave_display_idle = idle;
    exp_we = 1'b0;
    if (m_wait) begin
      if (idle) begin
        m_ri   = !m_ri;
        m_wait = 1'b0;
      end
    end else if (m_idx < 0) begin
      if (rdy && m_prev && !s[15]) begin
        exp_we   = 1'b1;
        exp_addr = m_ri ? 0 : 256;
        exp_data = ((int'(s) / 256) + 128) % 256;
        m_idx    = 1;
      end
    end else if (rdy) begin
      exp_we   = 1'b1;
      exp_addr = (m_ri ? 0 : 256) + m_idx;
      exp_data = ((int'(s) / 256) + 128) % 256;
      m_idx++;
      if (m_idx == 256) begin
        m_idx  = -1;
        m_wait = 1'b1;
      end
    end
    if (rdy) m_prev = s[15];
    @(posedge clk);
    #1;
    bus.new_sample_ready  = 1'b0;
    bus.wave_display_idle = 1'b0;
  endtask

  task automatic do_reset();
    reset                 = 1'b1;
    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = '0;
    bus.wave_display_idle = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    m_idx    = -1;
    m_wait   = 1'b0;
    m_ri     = 1'b0;
    m_prev   = 1'b0;
    exp_we   = 1'b0;
    exp_addr = 0;
    exp_data = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.write_enable !== 1'b0 || bus.write_address !== 9'h000 ||
        bus.write_sample !== 8'h00 || bus.read_index !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got we=%b addr=%h data=%h ri=%b want 0/000/00/0",
               bus.write_enable, bus.write_address, bus.write_sample, bus.read_index);
    end
  endtask

  task automatic test_trigger_window();
    int writes = 0;
    int first  = -1;
    int last   = -1;
    int n      = 0;
    while (!m_wait && n < 4000) begin
      step($urandom_range(0, 3) == 0, 16'($urandom_range(0, 65535)), $urandom_range(0, 1) == 1);
      n++;
      checks++;
      if (bus.write_enable !== exp_we) begin
        failures++;
        $display("FAIL window_we got %b want %b", bus.write_enable, exp_we);
      end
      if (exp_we) begin
        checks++;
        if (bus.write_address !== 9'(exp_addr) || bus.write_sample !== 8'(exp_data)) begin
          failures++;
          $display("FAIL window_write got %h/%h want %h/%h", bus.write_address,
                   bus.write_sample, 9'(exp_addr), 8'(exp_data));
        end
      end
      if (bus.write_enable === 1'b1) begin
        writes++;
        if (first < 0) first = int'(bus.write_address);
        last = int'(bus.write_address);
      end
    end
    checks++;
    if (!m_wait || writes != 256 || first != 'h100 || last != 'h1FF) begin
      failures++;
      $display("FAIL window_span got writes=%0d first=%h last=%h want 256/100/1ff",
               writes, first, last);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
      checks++;
      if (bus.write_enable !== 1'b0 || bus.read_index !== 1'b0) begin
        failures++;
        $display("FAIL wait_hold got we=%b ri=%b want 0/0", bus.write_enable, bus.read_index);
      end
    end
  endtask

  task automatic test_swap();
    step(1'b0, 16'h0000, 1'b1);
    checks++;
    if (bus.read_index !== 1'b1 || bus.write_enable !== 1'b0) begin
      failures++;
      $display("FAIL swap_ri got ri=%b we=%b want 1/0", bus.read_index, bus.write_enable);
    end
    step(1'b1, 16'h9000 | 16'($urandom_range(0, 4095)), 1'b1);
    step(1'b1, 16'($urandom_range(0, 32767)), 1'b1);
    checks++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h000 ||
        bus.write_sample !== 8'(exp_data)) begin
      failures++;
      $display("FAIL swap_first got we=%b addr=%h data=%h want 1/000/%h",
               bus.write_enable, bus.write_address, bus.write_sample, 8'(exp_data));
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    while (!m_wait && n < 400) begin
      step(1'b1, 16'($urandom_range(0, 65535)), $urandom_range(0, 1) == 1);
      n++;
      checks++;
      if (bus.write_enable !== exp_we || bus.write_address !== 9'(exp_addr) ||
          bus.write_sample !== 8'(exp_data) || bus.read_index !== m_ri) begin
        failures++;
        $display("FAIL b2b got we=%b addr=%h data=%h ri=%b want %b/%h/%h/%b",
                 bus.write_enable, bus.write_address, bus.write_sample, bus.read_index,
                 exp_we, 9'(exp_addr), 8'(exp_data), m_ri);
      end
    end
    checks++;
    if (!m_wait) begin
      failures++;
      $display("FAIL b2b_timeout got cycles=%0d want window done", n);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 16'h8123, 1'b0);
    step(1'b1, 16'hF000, 1'b1);
    checks++;
    if (bus.write_enable !== 1'b0 || bus.read_index !== 1'b0) begin
      failures++;
      $display("FAIL simul_drop got we=%b ri=%b want 0/0", bus.write_enable, bus.read_index);
    end
    step(1'b1, 16'h1234, 1'b0);
    checks++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h100 ||
        bus.write_sample !== 8'h92) begin
      failures++;
      $display("FAIL simul_rearm got we=%b addr=%h data=%h want 1/100/92",
               bus.write_enable, bus.write_address, bus.write_sample);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 99; i++) begin
      step(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
      checks++;
      if (bus.write_enable !== 1'b1 || bus.write_address !== 9'(exp_addr)) begin
        failures++;
        $display("FAIL mid_write got we=%b addr=%h want 1/%h",
                 bus.write_enable, bus.write_address, 9'(exp_addr));
      end
    end
    do_reset();
    checks++;
    if (bus.write_enable !== 1'b0 || bus.write_address !== 9'h000 ||
        bus.write_sample !== 8'h00 || bus.read_index !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got we=%b addr=%h data=%h ri=%b want 0/000/00/0",
               bus.write_enable, bus.write_address, bus.write_sample, bus.read_index);
    end
    step(1'b1, 16'h8000, 1'b0);
    step(1'b1, 16'h0100, 1'b0);
    checks++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h100) begin
      failures++;
      $display("FAIL mid_restart got we=%b addr=%h want 1/100",
               bus.write_enable, bus.write_address);
    end
  endtask

  task automatic test_endpoints();
    logic [15:0] vals [3] = '{16'h0000, 16'h7FFF, 16'h00FF};
    logic [7:0]  want [3] = '{8'h80, 8'hFF, 8'h80};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      step(1'b1, 16'hFFFF, 1'b0);
      step(1'b1, vals[i], 1'b0);
      checks++;
      if (bus.write_enable !== 1'b1 || bus.write_sample !== want[i] ||
          bus.write_sample !== 8'(exp_data)) begin
        failures++;
        $display("FAIL endpoint_%0d got we=%b data=%h want 1/%h",
                 i, bus.write_enable, bus.write_sample, want[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_trigger_window();
    test_swap();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    test_endpoints();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
# wave_capture

Downstream consumer of the music player's mixed output (`sample_normal` and `new_sample_generated`). It captures one 256-sample window of the waveform, starting at a positive-going zero crossing, into one half of a 512-entry double-buffered display RAM. It then waits for the wave display to go idle before swapping halves. The block drives only the RAM write port. The wave display reads the half selected by `read_index`.

## Interface

Parameters:
- `SAMPLE_WIDTH`, default 16: width of the incoming signed sample.
- `DEPTH_LOG2`, default 8: log2 of the samples per capture window.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high reset.
- `new_sample_ready`, input, 1: one-cycle pulse marking a valid `new_sample_in`. Driven from `new_sample_generated`.
- `new_sample_in`, input, `SAMPLE_WIDTH`: signed two's-complement sample. Driven from `sample_normal`.
- `wave_display_idle`, input, 1: high while the display is not reading the RAM.
- `write_address`, output, `DEPTH_LOG2+1`: RAM write address.
- `write_enable`, output, 1: RAM write strobe, one cycle.
- `write_sample`, output, 8: offset-binary display value.
- `read_index`, output, 1: RAM half owned by the display. The capture always writes half `~read_index`.

## Operation

State machine with three states, `ARMED`, `ACTIVE` and `WAIT`. Reset state is `ARMED`.
- **Previous-sample register.** `prev_msb` holds bit `SAMPLE_WIDTH-1` of the last sample. It is updated on every `new_sample_ready` pulse, in every state.
- **Zero crossing.** A zero crossing is a `new_sample_ready` pulse with `prev_msb`=1 and `new_sample_in[SAMPLE_WIDTH-1]`=0.
- **`ARMED`**
  - Ready pulses without a crossing are not written.
  - On a crossing, the triggering sample is written at index 0, `count` becomes 1, and the state goes to `ACTIVE`.
- **`ACTIVE`**
  - Each ready pulse writes at index `count`, then `count` increments.
  - The pulse that writes index 255 (`count` = 2^`DEPTH_LOG2`-1) moves the state to `WAIT`, and `count` wraps to 0.
- **`WAIT`**
  - Ready pulses are ignored, apart from the `prev_msb` update.
  - On the first cycle with `wave_display_idle`=1, `read_index` toggles and the state returns to `ARMED`.
- **Address.** `write_address` = {~`read_index`, `count`}, using the `count` value before the increment.
- **Data.** `write_sample` = {~`new_sample_in[15]`, `new_sample_in[14:8]`}, i.e. the top 8 bits converted to offset binary. Examples: 0x8000→0x00, 0x0000→0x80, 0x7FFF→0xFF.
- **`wave_display_idle` outside `WAIT`.** It has no effect in `ARMED` or `ACTIVE`.
- **Ready pulse and idle in the same `WAIT` cycle.** The sample is not written. The state moves to `ARMED`, and the next pulse may trigger a capture.
- **Reset mid-capture.** The partial window is abandoned. `count`=0, state=`ARMED`, `read_index`=0, `prev_msb`=0. RAM contents are not cleared.

## Timing

- **Reset values.** `write_enable`=0, `write_address`=0, `write_sample`=0, `read_index`=0.
- **Write latency.** `write_address`, `write_sample` and `write_enable` are registered. They are valid for exactly one cycle, starting the cycle after the qualifying `new_sample_ready` pulse. `write_enable` is 0 at all other times.
- **State update.** `count` and the state register update on the same edge that registers the write outputs.
- **`read_index` toggle.** It toggles one cycle after `wave_display_idle` is sampled high in `WAIT`. The first possible new write, to the new back half, occurs on the next crossing pulse after that.
- **Back-to-back pulses.** The block accepts a ready pulse every cycle with no throughput loss. In the system, pulses arrive at 48 kHz.
- **Ownership.** While not in `WAIT`, the block never writes the half equal to `read_index`.

## Structure

- **Shared package `wave_pkg`:**
  - state encodings (`WC_ARMED`=2'd0, `WC_ACTIVE`=2'd1, `WC_WAIT`=2'd2);
  - `WAVE_DEPTH_LOG2`=8;
  - `WAVE_PIXEL_WIDTH`=8.

  The wave display imports the same package.
- **Registers.** State, `count`, `prev_msb` and `read_index` are built from the existing `dff` register cell. Next-state logic is a single combinational always block.
- **No further sub-module.** The block is a single FSM plus counter.

## Test plan

- **Trigger and first write.** After reset, drive a sine from 0x8000 through 0x7FFF, one pulse per 4 cycles. No `write_enable` until the first negative→non-negative pulse. That pulse yields `write_address`=0x100 and a `write_sample` matching the conversion rule, one cycle later.
- **Full window.** After the trigger, 255 more pulses produce addresses 0x101–0x1FF in order, then writes stop. A further 20 pulses with `wave_display_idle`=0 produce no writes.
- **Swap.** In `WAIT`, raise `wave_display_idle`. `read_index` goes 0→1 one cycle later. The next crossing writes starting at address 0x000.
- **Simultaneous pulse and idle.** A ready pulse in the same cycle idle is first high in `WAIT` produces no write. The state returns to `ARMED`.
- **Reset mid-window.** Assert `reset` after 100 writes. All outputs return to reset values. The next crossing restarts at address 0x100.
- **Conversion endpoints.** Triggered samples 0x0000, 0x7FFF and 0x00FF produce `write_sample` 0x80, 0xFF and 0x80 respectively.
